noc_router: RTL and testbench

//   Per-hop route-computation stage for a 2-D mesh NoC using deterministic

---
 rtl/noc_router.sv | 70 +++++++
 tb/tb_noc_router.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/noc_router.sv
// Even-odd turn-model route computation for one 2-D mesh hop.
// Picks an output port for the flit and forwards its payload, both registered.
module noc_router #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned X_SIZE = 4,
  parameter int unsigned Y_SIZE = 4,
  parameter int unsigned X_BITS = $clog2(X_SIZE),
  parameter int unsigned Y_BITS = $clog2(Y_SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  data_in,
  input  logic [X_BITS-1:0] current_x,
  input  logic [Y_BITS-1:0] current_y,
  input  logic [X_BITS-1:0] dest_x,
  input  logic [Y_BITS-1:0] dest_y,
  output logic [WIDTH-1:0]  data_out,
  output logic [2:0]        direction
);

  localparam logic [2:0] DIR_LOCAL   = 3'b000;
  localparam logic [2:0] DIR_NORTH   = 3'b001;
  localparam logic [2:0] DIR_EAST    = 3'b010;
  localparam logic [2:0] DIR_SOUTH   = 3'b011;
  localparam logic [2:0] DIR_WEST    = 3'b100;
  localparam logic [2:0] DIR_INVALID = 3'b111;

  // One extra bit so that SIZE itself is representable when it is a power of 2
  localparam logic [X_BITS:0] X_LIM = (X_BITS + 1)'(X_SIZE);
  localparam logic [Y_BITS:0] Y_LIM = (Y_BITS + 1)'(Y_SIZE);

  logic       invalid_c;
  logic [2:0] vertical_c;
  logic [2:0] route_c;

  always_comb begin
    invalid_c = ({1'b0, current_x} >= X_LIM) || ({1'b0, dest_x} >= X_LIM) ||
                ({1'b0, current_y} >= Y_LIM) || ({1'b0, dest_y} >= Y_LIM);
    vertical_c = (dest_y > current_y) ? DIR_NORTH : DIR_SOUTH;
  end

  // Even columns may not turn E->N/S; odd columns may not turn N/S->W
  always_comb begin
    route_c = DIR_LOCAL;
    if (invalid_c) begin
      route_c = DIR_INVALID;
    end else if (dest_x == current_x) begin
      route_c = (dest_y == current_y) ? DIR_LOCAL : vertical_c;
    end else if (dest_x > current_x) begin
      if (dest_y == current_y)  route_c = DIR_EAST;
      else if (current_x[0])    route_c = vertical_c;
      else                      route_c = DIR_EAST;
    end else begin
      if (dest_y == current_y)  route_c = DIR_WEST;
      else if (!current_x[0])   route_c = vertical_c;
      else                      route_c = DIR_WEST;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out  <= '0;
      direction <= DIR_LOCAL;
    end else begin
      direction <= route_c;
      data_out  <= (route_c == DIR_INVALID) ? '0 : data_in;
    end
  end

endmodule

// File: tb/tb_noc_router.sv
// Directed and follow-through checks of noc_router on a 4x4 mesh,
// plus a 3-column instance for out-of-range coordinate handling.
module tb_noc_router;

  localparam int unsigned WIDTH = 32;

  localparam logic [2:0] L = 3'b000;
  localparam logic [2:0] N = 3'b001;
  localparam logic [2:0] E = 3'b010;
  localparam logic [2:0] S = 3'b011;
  localparam logic [2:0] W = 3'b100;
  localparam logic [2:0] INV = 3'b111;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] data_in;
  logic [1:0]       current_x, current_y, dest_x, dest_y;
  logic [WIDTH-1:0] data_out, data_out3;
  logic [2:0]       direction, direction3;

  int n_checks;
  int n_fail;

  noc_router #(.WIDTH(WIDTH), .X_SIZE(4), .Y_SIZE(4)) u_dut (
    .clk(clk), .rst(rst), .data_in(data_in),
    .current_x(current_x), .current_y(current_y),
    .dest_x(dest_x), .dest_y(dest_y),
    .data_out(data_out), .direction(direction)
  );

  noc_router #(.WIDTH(WIDTH), .X_SIZE(3), .Y_SIZE(4)) u_dut3 (
    .clk(clk), .rst(rst), .data_in(data_in),
    .current_x(current_x), .current_y(current_y),
    .dest_x(dest_x), .dest_y(dest_y),
    .data_out(data_out3), .direction(direction3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drive one hop's inputs at the falling edge, sample 1 time unit after the next rising edge
  task automatic step(input int cx, input int cy, input int dx, input int dy, input logic [31:0] d);
    @(negedge clk);
    current_x = 2'(cx);
    current_y = 2'(cy);
    dest_x    = 2'(dx);
    dest_y    = 2'(dy);
    data_in   = d;
    @(posedge clk);
    #1;
  endtask

  task automatic route_check(input string tag, input int cx, input int cy, input int dx,
                             input int dy, input logic [2:0] exp_dir);
    step(cx, cy, dx, dy, 32'hDEADBEEF);
    check_eq(tag, 32'(direction), 32'(exp_dir));
  endtask

  initial begin
    int sx, sy, tx, ty, cx, cy, hops, bad, man;
    logic [2:0] prev, d;
    logic done;
    n_checks = 0;
    n_fail   = 0;
    rst       = 1'b0;
    data_in   = 32'h12345678;
    current_x = 2'd0;
    current_y = 2'd0;
    dest_x    = 2'd3;
    dest_y    = 2'd3;

    // Reset holds outputs at zero despite clocking and live inputs
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset data_out", data_out, 32'h0);
    check_eq("reset direction", 32'(direction), 32'(L));
    @(negedge clk);
    rst = 1'b1;

    // Eastbound walk toward (3,3)
    route_check("walk (0,0)", 0, 0, 3, 3, E);
    check_eq("walk data_out", data_out, 32'hDEADBEEF);
    route_check("walk (1,0)", 1, 0, 3, 3, N);
    route_check("walk (2,0)", 2, 0, 3, 3, E);
    route_check("walk (3,1)", 3, 1, 3, 3, N);
    route_check("walk (3,2)", 3, 2, 3, 3, N);
    route_check("walk (3,3)", 3, 3, 3, 3, L);
    check_eq("local data_out", data_out, 32'hDEADBEEF);

    // Async reset clears outputs without a clock edge
    #2;
    rst = 1'b0;
    #1;
    check_eq("async rst data_out", data_out, 32'h0);
    check_eq("async rst direction", 32'(direction), 32'(L));
    @(negedge clk);
    rst = 1'b1;

    // Westbound toward (0,3)
    route_check("west (3,0)", 3, 0, 0, 3, W);
    route_check("west (2,0)", 2, 0, 0, 3, N);
    route_check("west (2,3)", 2, 3, 0, 3, W);
    route_check("west (1,3)", 1, 3, 0, 3, W);
    route_check("west (0,3)", 0, 3, 0, 3, L);

    // Same row / same column
    route_check("col south", 1, 2, 1, 0, S);
    route_check("row east", 1, 2, 3, 2, E);
    route_check("row west", 1, 2, 0, 2, W);
    route_check("odd west dy", 3, 3, 1, 0, W);
    route_check("even east dy", 0, 3, 2, 1, E);

    // 3-column mesh: column 3 is off the mesh
    step(0, 0, 3, 0, 32'hCAFEF00D);
    check_eq("x3 invalid dir", 32'(direction3), 32'(INV));
    check_eq("x3 invalid data", data_out3, 32'h0);
    step(3, 1, 0, 1, 32'hCAFEF00D);
    check_eq("x3 bad cur dir", 32'(direction3), 32'(INV));
    step(0, 0, 2, 0, 32'hCAFEF00D);
    check_eq("x3 valid dir", 32'(direction3), 32'(E));
    check_eq("x3 valid data", data_out3, 32'hCAFEF00D);

    // Follow every (source,dest) pair hop by hop
    for (int p = 0; p < 256; p++) begin
      sx = p[7:6]; sy = p[5:4]; tx = p[3:2]; ty = p[1:0];
      cx = sx; cy = sy; hops = 0; bad = 0; done = 1'b0; prev = L;
      for (int h = 0; h < 12 && !done; h++) begin
        step(cx, cy, tx, ty, 32'(p));
        d = direction;
        if (d == L) begin
          done = 1'b1;
          if (cx != tx || cy != ty) bad++;
        end else begin
          if ((d == N || d == S) && prev == E && cx[0] == 1'b0) bad++;
          if (d == W && (prev == N || prev == S) && cx[0] == 1'b1) bad++;
          case (d)
            N: if (cy == 3) begin bad++; done = 1'b1; end else cy++;
            S: if (cy == 0) begin bad++; done = 1'b1; end else cy--;
            E: if (cx == 3) begin bad++; done = 1'b1; end else cx++;
            W: if (cx == 0) begin bad++; done = 1'b1; end else cx--;
            default: begin bad++; done = 1'b1; end
          endcase
          hops++;
          prev = d;
        end
      end
      if (!done) hops = 99;
      man = ((tx > sx) ? tx - sx : sx - tx) + ((ty > sy) ? ty - sy : sy - ty);
      check_eq($sformatf("sweep hops %0d%0d->%0d%0d", sx, sy, tx, ty), 32'(hops), 32'(man));
      check_eq($sformatf("sweep turns %0d%0d->%0d%0d", sx, sy, tx, ty), 32'(bad), 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
